avalon_led_pio_blink: RTL and testbench

- Parametrised successor to the fixed 10-bit LED output PIO.
- Avalon-MM slave with zero-wait-state writes and zero-latency combinational reads.
- Drives WIDTH output bits through these registers: data, per-bit blink mode, atomic set/clear, and a shared blink-period register.
- Sits on the lightweight bus in the lab Qsys system; out_port connects to board LEDs.

---
 rtl/led_pio_pkg.sv | 22 ++
 rtl/led_blink_timer.sv | 45 ++++
 rtl/avalon_led_pio_blink.sv | 135 +++++++++++++
 tb/tb_avalon_led_pio_blink.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared register map, IRQ bit positions and STATUS field layout for the
// blinking LED PIO.
package led_pio_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_OUTSET = 3'd2;
  localparam logic [2:0] ADDR_OUTCLR = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_IRQ    = 3'd6;
  localparam logic [2:0] ADDR_RSVD   = 3'd7;

  localparam int unsigned IRQ_ENABLE_BIT  = 0;
  localparam int unsigned IRQ_PENDING_BIT = 1;

  localparam int unsigned STATUS_PHASE_BIT = 0;
  localparam int unsigned STATUS_CNT_LSB   = 1;

endpackage

// File: rtl/led_blink_timer.sv
// Free-running blink half-period counter with a phase flop; load restarts
// the count with phase on, and rise flags a phase 0->1 transition.
module led_blink_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic [PERIOD_W-1:0] cnt,
  output logic                phase,
  output logic                phase_next,
  output logic                rise
);

  logic [PERIOD_W-1:0] cnt_next;

  // A zero period freezes the counter with the LEDs held on.
  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (load || period == '0) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt == period - PERIOD_W'(1)) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end else begin
      cnt_next = cnt + PERIOD_W'(1);
    end
  end

  assign rise = ~phase & phase_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/avalon_led_pio_blink.sv
// Avalon-MM LED PIO with per-bit blink, atomic set/clear and shared period.
// Define LED_PIO_IRQ_EN to add the irq port and the IRQ register at address 6.
module avalon_led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned RESET_DATA   = 0,
  parameter int unsigned RESET_PERIOD = 2500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef LED_PIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [WIDTH-1:0]    RST_DATA   = WIDTH'(RESET_DATA);
  localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(RESET_PERIOD);

  logic                wr;
  logic [WIDTH-1:0]    wd;
  logic                period_load;
  logic [WIDTH-1:0]    data, data_next;
  logic [WIDTH-1:0]    mode, mode_next;
  logic [PERIOD_W-1:0] period, period_next;
  logic [PERIOD_W-1:0] cnt;
  logic                phase, phase_next, rise;
  logic [PERIOD_W:0]   status_raw;
  logic                unused_bits;

  assign wr          = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign period_load = wr && (address == ADDR_PERIOD);
  assign unused_bits = ^writedata ^ rise;

  always_comb begin
    data_next   = data;
    mode_next   = mode;
    period_next = period;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_next   = wd;
        ADDR_MODE:   mode_next   = wd;
        ADDR_OUTSET: data_next   = data | wd;
        ADDR_OUTCLR: data_next   = data & ~wd;
        ADDR_PERIOD: period_next = writedata[PERIOD_W-1:0];
        default:     ;
      endcase
    end
  end

  led_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .period     (period),
    .load       (period_load),
    .cnt        (cnt),
    .phase      (phase),
    .phase_next (phase_next),
    .rise       (rise)
  );

  // out_port is built from next-state values so it tracks writes and phase
  // with exactly one clock of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= RST_DATA;
      mode     <= '0;
      period   <= RST_PERIOD;
      out_port <= RST_DATA;
    end else begin
      data     <= data_next;
      mode     <= mode_next;
      period   <= period_next;
      out_port <= data_next & (~mode_next | {WIDTH{phase_next}});
    end
  end

`ifdef LED_PIO_IRQ_EN
  logic irq_enable;
  logic irq_pending;
  logic irq_wr;

  assign irq_wr = wr && (address == ADDR_IRQ);

  // A phase rise on the same edge as a write-1-to-clear keeps pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable  <= 1'b0;
      irq_pending <= 1'b0;
      irq         <= 1'b0;
    end else begin
      irq <= irq_enable & irq_pending;
      if (irq_wr) irq_enable <= writedata[IRQ_ENABLE_BIT];
      if (rise) irq_pending <= 1'b1;
      else if (irq_wr && writedata[IRQ_PENDING_BIT]) irq_pending <= 1'b0;
    end
  end
`endif

  always_comb begin
    status_raw = '0;
    status_raw[STATUS_PHASE_BIT] = phase;
    status_raw[STATUS_CNT_LSB +: PERIOD_W] = cnt;
  end

  // STATUS is truncated to the bus width when PERIOD_W is 32.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR: readdata = BUS_W'(data);
      ADDR_MODE:   readdata = BUS_W'(mode);
      ADDR_PERIOD: readdata = BUS_W'(period);
      ADDR_STATUS: readdata = BUS_W'(status_raw);
`ifdef LED_PIO_IRQ_EN
      ADDR_IRQ: begin
        readdata[IRQ_ENABLE_BIT]  = irq_enable;
        readdata[IRQ_PENDING_BIT] = irq_pending;
      end
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_led_pio_blink.sv
// Bench for avalon_led_pio_blink: directed literal checks plus random traffic
// compared every cycle against a time-based model of the blink behaviour.
module tb_avalon_led_pio_blink;

  localparam int unsigned W     = 10;
  localparam int unsigned PW    = 24;
  localparam int unsigned RD    = 32'h2A5;
  localparam int unsigned RP    = 2500000;
  localparam int unsigned MASK  = (1 << W) - 1;
  localparam int unsigned PMASK = (1 << PW) - 1;
`ifdef LED_PIO_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
`ifdef LED_PIO_IRQ_EN
  logic          irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  avalon_led_pio_blink #(
    .WIDTH        (W),
    .PERIOD_W     (PW),
    .RESET_DATA   (RD),
    .RESET_PERIOD (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
`ifdef LED_PIO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  // Model: t counts cycles since the last restart; phase and cnt follow from t.
  int unsigned m_data, m_mode, m_period, m_t;
  bit          m_en, m_pend, m_irq, m_valid = 1'b0;

  function automatic bit m_phase();
    if (m_period == 0) return 1'b1;
    return ((m_t / m_period) % 2) == 0;
  endfunction

  function automatic int unsigned m_cnt();
    if (m_period == 0) return 0;
    return m_t % m_period;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd2, 3'd3: return m_data;
      3'd1: return m_mode;
      3'd4: return m_period;
      3'd5: return (m_cnt() << 1) | 32'(m_phase());
      3'd6: return IRQ_BUILD ? {30'd0, m_pend, m_en} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int unsigned m_out();
    int unsigned ph_mask;
    ph_mask = m_phase() ? MASK : 0;
    return m_data & (~m_mode | ph_mask) & MASK;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : model_update
    bit          wr, ph0, ph1;
    logic [31:0] wd;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_data = RD & MASK; m_mode = 0; m_period = RP; m_t = 0;
        m_en = 0; m_pend = 0; m_irq = 0; m_valid = 1'b1;
      end else if (m_valid) begin
        wr  = chipselect && !write_n;
        wd  = writedata;
        ph0 = m_phase();
        m_irq = m_en && m_pend;
        if (wr && address == 3'd4) begin
          m_period = wd & PMASK;
          m_t = 0;
        end else begin
          m_t = (m_period == 0) ? 0 : m_t + 1;
        end
        if (wr) begin
          case (address)
            3'd0: m_data = wd & MASK;
            3'd1: m_mode = wd & MASK;
            3'd2: m_data = (m_data | wd) & MASK;
            3'd3: m_data = m_data & ~wd & MASK;
            3'd6: if (IRQ_BUILD) begin
                    m_en = wd[0];
                    if (wd[1]) m_pend = 1'b0;
                  end
            default: ;
          endcase
        end
        ph1 = m_phase();
        if (!ph0 && ph1) m_pend = 1'b1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("model_out_port", 32'(out_port), m_out());
        check("model_readdata", readdata, m_read(address));
`ifdef LED_PIO_IRQ_EN
        check("model_irq", 32'(irq), 32'(m_irq));
`endif
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic look(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk); #1;
    chipselect = 1'b0;
  endtask

  initial begin : stim
    bit ph;
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    look(3'd5); check("rst_status", readdata, 32'h1);
    check("rst_out", 32'(out_port), RD); step();
    look(3'd0); check("rst_data", readdata, RD); step();
    look(3'd1); check("rst_mode", readdata, 32'h0); step();
    look(3'd4); check("rst_period", readdata, 32'd2500000); step();
    look(3'd7); check("rsvd_read", readdata, 32'h0); step();
    look(3'd6); check("irq_reg_rst", readdata, 32'h0); step();

    wr(3'd0, 32'hFFFF_F3FF);
    look(3'd0); check("data_wr", readdata, 32'h3FF); check("data_out", 32'(out_port), 32'h3FF); step();
    wr(3'd3, 32'h0000_000F);
    look(3'd3); check("outclr", readdata, 32'h3F0); check("outclr_out", 32'(out_port), 32'h3F0); step();
    wr(3'd2, 32'h0000_0001);
    look(3'd2); check("outset", readdata, 32'h3F1); check("outset_out", 32'(out_port), 32'h3F1); step();
    wr(3'd7, 32'hFFFF_FFFF);
    look(3'd0); check("rsvd_wr_ignored", readdata, 32'h3F1); step();

    wr(3'd1, 32'h3); wr(3'd0, 32'h3FF); wr(3'd4, 32'd4);
    for (int k = 0; k < 16; k++) begin
      ph = ((k / 4) % 2) == 0;
      look(3'd5);
      check("blink_lo", 32'(out_port[1:0]), ph ? 32'h3 : 32'h0);
      check("blink_hi", 32'(out_port[9:2]), 32'hFF);
      check("blink_status", readdata, 32'(((k % 4) << 1) | int'(ph)));
      step();
    end

    wr(3'd4, 32'd0);
    for (int k = 0; k < 10; k++) begin
      look(3'd5);
      check("frozen_lo", 32'(out_port[1:0]), 32'h3);
      check("frozen_status", readdata, 32'h1);
      step();
    end
    wr(3'd4, 32'd2);
    for (int k = 0; k < 8; k++) begin
      ph = ((k / 2) % 2) == 0;
      look(3'd5);
      check("p2_lo", 32'(out_port[1:0]), ph ? 32'h3 : 32'h0);
      check("p2_status", readdata, 32'(((k % 2) << 1) | int'(ph)));
      step();
    end

    wr(3'd4, 32'd4);
    repeat (6) step();
    look(3'd5); check("pre_reset_status", readdata, 32'h4);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    look(3'd5); check("midreset_status", readdata, 32'h1);
    check("midreset_out", 32'(out_port), RD); step();
    look(3'd4); check("midreset_period", readdata, 32'd2500000); step();
    look(3'd1); check("midreset_mode", readdata, 32'h0); step();
    look(3'd0); check("midreset_data", readdata, RD); step();

`ifdef LED_PIO_IRQ_EN
    wr(3'd6, 32'h1);
    wr(3'd4, 32'd3);
    for (int k = 0; k < 20; k++) begin
      bit ep, ep_prev;
      ep      = (k >= 6 && k < 8) || (k >= 12);
      ep_prev = (k >= 7 && k < 9) || (k >= 13);
      address = 3'd6; chipselect = 1'b1;
      write_n = !(k == 7 || k == 17);
      writedata = 32'h3;
      @(negedge clk);
      check("irq_reg", readdata, {30'd0, ep, 1'b1});
      check("irq_line", 32'(irq), 32'(ep_prev));
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
    end
`endif

    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = 1'($urandom_range(0, 1));
      writedata  = (address == 3'd4) ? (($urandom & 32'hFF00_0000) | $urandom_range(0, 6))
                                     : $urandom;
      @(posedge clk); #1;
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
